// File: rtl/cacheline_burst_adaptor.sv
// Splits one 256-bit cacheline request into a BEATS-long burst of BEAT_W-bit
// memory transfers and reassembles read bursts into a single line response.
module cacheline_burst_adaptor #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_read,
    input  logic                    line_write,
    input  logic [ADDR_W-1:0]       line_addr,
    input  logic [BEATS*BEAT_W-1:0] line_wdata,
    output logic                    line_resp,
    output logic [BEATS*BEAT_W-1:0] line_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [BEAT_W-1:0]       mem_wdata,
    input  logic [BEAT_W-1:0]       mem_rdata,
    input  logic                    mem_resp
);
    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                         state_reg, state_next;
    logic [CNT_W-1:0]               beat_cnt_reg;
    logic [ADDR_W-1:0]              addr_reg;
    logic [BEATS-1:0][BEAT_W-1:0]   wbuf_reg;
    logic [BEATS-1:0][BEAT_W-1:0]   rbuf_reg;
    logic [BEATS-1:0][BEAT_W-1:0]   rbuf_next;
    logic [BEATS-1:0][BEAT_W-1:0]   line_wdata_beats;
    logic [LINE_W-1:0]              line_rdata_reg;
    logic                           last_beat;
    logic                           unused_addr_bits;

    // Byte offset within the line is irrelevant: bursts are line-aligned.
    assign unused_addr_bits = ^line_addr[OFF_W-1:0];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
            assign line_wdata_beats[gi] = line_wdata[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    assign last_beat = mem_resp && (beat_cnt_reg == CNT_W'(BEATS - 1));

    always_comb begin
        rbuf_next               = rbuf_reg;
        rbuf_next[beat_cnt_reg] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (line_read) begin
                    state_next = RD;
                end else if (line_write) begin
                    state_next = WR;
                end
            end
            RD:      if (last_beat) state_next = DONE;
            WR:      if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg   <= '0;
            addr_reg       <= '0;
            wbuf_reg       <= '0;
            rbuf_reg       <= '0;
            line_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (line_read || line_write) begin
                        addr_reg <= {line_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end
                    if (!line_read && line_write) begin
                        wbuf_reg <= line_wdata_beats;
                    end
                end
                RD: begin
                    if (mem_resp) begin
                        rbuf_reg     <= rbuf_next;
                        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
                    end
                    // Only a completed burst becomes visible to the arbiter.
                    if (last_beat) begin
                        line_rdata_reg <= rbuf_next;
                    end
                end
                WR: begin
                    if (mem_resp) begin
                        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign line_resp  = (state_reg == DONE);
    assign mem_read   = (state_reg == RD);
    assign mem_write  = (state_reg == WR);
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wbuf_reg[beat_cnt_reg];
    assign line_rdata = line_rdata_reg;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: expected lines and write beats
// are queued when a request is driven and checked as the DUT produces them.
module tb_cacheline_burst_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic         line_resp;
    logic [255:0] line_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [255:0] rq[$];
    logic [63:0]  wq[$];
    logic [255:0] prev_line;

    cacheline_burst_adaptor dut (
        .clk        (clk),
        .rst        (rst),
        .line_read  (line_read),
        .line_write (line_write),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_resp  (line_resp),
        .line_rdata (line_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a read request; pat bit i is mem_resp in burst cycle i+1 (1 past plen).
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input logic [31:0] pat, input int plen,
                           input logic with_write, input string tag, output int resp_cyc);
        int  beat;
        int  cyc;
        logic done;
        logic r;
        beat = 0; cyc = 1; done = 1'b0; resp_cyc = -1;
        line_read  = 1'b1;
        line_write = with_write;
        line_addr  = addr;
        line_wdata = {8{32'hBADC0FFE}};
        rq.push_back(line);
        tick();
        while (!done && cyc <= 40) begin
            if (line_resp) begin
                resp_cyc = cyc;
                check({tag, " rdata"}, line_rdata, rq.pop_front());
                check({tag, " beats"}, 256'(beat), 256'(4));
                check({tag, " done_rd"}, 256'(mem_read), 256'(0));
                line_read  = 1'b0;
                line_write = 1'b0;
                mem_resp   = 1'b0;
                done = 1'b1;
            end else begin
                check({tag, " mem_read"}, 256'(mem_read), 256'(1));
                check({tag, " mem_write"}, 256'(mem_write), 256'(0));
                check({tag, " mem_addr"}, 256'(mem_addr), 256'({addr[31:5], 5'b0}));
                r = (cyc <= plen) ? pat[cyc-1] : 1'b1;
                if (r && beat < 4) begin
                    mem_rdata = line[beat*64 +: 64];
                    beat++;
                end else begin
                    r = 1'b0;
                    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                mem_resp = r;
                tick();
                cyc++;
            end
        end
        if (!done) begin
            check({tag, " timeout"}, 256'(0), 256'(1));
            line_read = 1'b0; line_write = 1'b0; mem_resp = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [31:0] pat, input int plen,
                            input string tag, output int resp_cyc);
        int  cyc;
        logic done;
        logic r;
        cyc = 1; done = 1'b0; resp_cyc = -1;
        line_write = 1'b1;
        line_read  = 1'b0;
        line_addr  = addr;
        line_wdata = line;
        for (int k = 0; k < 4; k++) wq.push_back(line[k*64 +: 64]);
        tick();
        while (!done && cyc <= 40) begin
            if (line_resp) begin
                resp_cyc = cyc;
                check({tag, " beats_left"}, 256'(wq.size()), 256'(0));
                check({tag, " rdata_kept"}, line_rdata, prev_line);
                check({tag, " done_wr"}, 256'(mem_write), 256'(0));
                line_write = 1'b0;
                mem_resp   = 1'b0;
                done = 1'b1;
            end else begin
                check({tag, " mem_write"}, 256'(mem_write), 256'(1));
                check({tag, " mem_read"}, 256'(mem_read), 256'(0));
                check({tag, " mem_addr"}, 256'(mem_addr), 256'({addr[31:5], 5'b0}));
                if (wq.size() > 0) begin
                    check({tag, " mem_wdata"}, 256'(mem_wdata), 256'(wq[0]));
                end
                r = (cyc <= plen) ? pat[cyc-1] : 1'b1;
                if (r && wq.size() > 0) begin
                    void'(wq.pop_front());
                end else begin
                    r = 1'b0;
                end
                mem_resp = r;
                tick();
                cyc++;
            end
        end
        if (!done) begin
            check({tag, " timeout"}, 256'(0), 256'(1));
            line_write = 1'b0; mem_resp = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] line1, line2, line3, line4, line5, wline;
        int rc;
        line1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        line2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        line3 = {64'hC3C3_0000_1111_2222, 64'h3333_4444_5555_6666,
                 64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DDDD_EEEE};
        line4 = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        line5 = {64'hA5A5_A5A5_0000_0005, 64'h5A5A_5A5A_0000_0006,
                 64'h9999_0000_0000_0007, 64'h6666_0000_0000_0008};
        wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

        rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
        line_addr = '0; line_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        tick();
        tick();
        $display("[TB] reset");
        check("rst line_resp", 256'(line_resp), 256'(0));
        check("rst mem_read", 256'(mem_read), 256'(0));
        check("rst mem_write", 256'(mem_write), 256'(0));
        check("rst mem_addr", 256'(mem_addr), 256'(0));
        check("rst mem_wdata", 256'(mem_wdata), 256'(0));
        check("rst line_rdata", line_rdata, 256'(0));
        rst = 1'b0;
        tick();

        do_read(32'h0000_1234, line1, 32'hFFFF_FFFF, 4, 1'b0, "rd_nostall", rc);
        check("rd_nostall latency", 256'(rc), 256'(5));
        $display("[TB] read no-stall addr=00001234 resp_cycle=%0d", rc);
        tick();
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        mem_resp = 1'b0;
        check("idle resp ignored rd", 256'(mem_read), 256'(0));
        check("idle resp ignored lr", 256'(line_resp), 256'(0));
        check("idle rdata held", line_rdata, line1);

        do_read(32'h0000_0040, line2, 32'h0000_0069, 7, 1'b0, "rd_stall", rc);
        check("rd_stall latency", 256'(rc), 256'(8));
        $display("[TB] read stalled addr=00000040 resp_cycle=%0d", rc);
        prev_line = line2;
        tick();

        do_write(32'h8000_00FF, wline, 32'h0000_002D, 6, "wr_stall", rc);
        check("wr_stall latency", 256'(rc), 256'(7));
        $display("[TB] write stalled addr=800000FF resp_cycle=%0d", rc);
        tick();

        do_read(32'h0000_3000, line3, 32'hFFFF_FFFF, 4, 1'b1, "rd_and_wr", rc);
        check("rd_and_wr latency", 256'(rc), 256'(5));
        $display("[TB] simultaneous read+write resp_cycle=%0d", rc);
        tick();

        line_read = 1'b1; line_addr = 32'h0000_2000;
        tick();
        mem_resp = 1'b1; mem_rdata = 64'h9999_9999_9999_9999;
        tick();
        mem_rdata = 64'h8888_8888_8888_8888;
        tick();
        check("midrst mem_read", 256'(mem_read), 256'(1));
        rst = 1'b1; line_read = 1'b0; mem_resp = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst rd after", 256'(mem_read), 256'(0));
        check("midrst rdata", line_rdata, 256'(0));
        check("midrst line_resp", 256'(line_resp), 256'(0));
        tick();
        check("midrst idle resp", 256'(line_resp), 256'(0));
        check("midrst idle rd", 256'(mem_read), 256'(0));
        $display("[TB] reset mid-burst after 2 beats");
        do_read(32'h0000_2000, line4, 32'hFFFF_FFFF, 4, 1'b0, "rd_after_rst", rc);
        check("rd_after_rst latency", 256'(rc), 256'(5));
        $display("[TB] fresh read after reset resp_cycle=%0d", rc);
        tick();

        do_read(32'h0000_5000, line5, 32'hFFFF_FFFF, 4, 1'b0, "b2b_rd", rc);
        check("b2b_rd latency", 256'(rc), 256'(5));
        tick();
        check("b2b idle rd", 256'(mem_read), 256'(0));
        check("b2b idle wr", 256'(mem_write), 256'(0));
        check("b2b idle resp", 256'(line_resp), 256'(0));
        prev_line = line5;
        do_write(32'h0000_6010, wline, 32'hFFFF_FFFF, 4, "b2b_wr", rc);
        check("b2b_wr latency", 256'(rc), 256'(5));
        tick();
        check("b2b no extra wr", 256'(mem_write), 256'(0));
        check("b2b no extra rd", 256'(mem_read), 256'(0));
        tick();
        check("b2b no extra resp", 256'(line_resp), 256'(0));
        $display("[TB] back-to-back read then write resp_cycle=%0d", rc);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
